// File: rtl/bnn_load_tx_pkg.sv
// Shared geometry and state encoding for the serial image/weight load transmitter.
// Pixel and weight counts are derived from the image side and the filter shape.
package bnn_pkg;
    localparam int IMG_DIM = 28;
    localparam int K_DIM   = 3;
    localparam int N_FILT  = 8;
    localparam int N_PIX   = IMG_DIM * IMG_DIM;
    localparam int N_WGT   = N_FILT * K_DIM * K_DIM;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERR
    } tx_state_t;
endpackage

// File: rtl/bnn_load_tx_seq_counter.sv
// Row/col pixel walk plus level/trit/bit weight walk, advanced together on each strobe.
// Zero latency to the index outputs; en low holds position, clr restarts at pixel 0.
module load_seq_counter
    import bnn_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic [2:0] lvl,
    output logic [1:0] trt,
    output logic [1:0] bt,
    output logic       w_act,
    output logic       last
);
    logic [9:0] idx;
    logic [6:0] widx;

    assign last  = (idx == 10'(N_PIX - 1));
    assign w_act = (widx < 7'(N_WGT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            row  <= '0;
            col  <= '0;
            widx <= '0;
            lvl  <= '0;
            trt  <= '0;
            bt   <= '0;
        end else if (clr) begin
            idx  <= '0;
            row  <= '0;
            col  <= '0;
            widx <= '0;
            lvl  <= '0;
            trt  <= '0;
            bt   <= '0;
        end else if (en) begin
            // idx parks on the final pixel so row/col never run past the image
            if (!last) begin
                idx <= idx + 10'd1;
                if (col == 5'(IMG_DIM - 1)) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
            if (w_act) begin
                widx <= widx + 7'd1;
                if (bt == 2'(K_DIM - 1)) begin
                    bt <= '0;
                    if (trt == 2'(K_DIM - 1)) begin
                        trt <= '0;
                        lvl <= lvl + 3'd1;
                    end else begin
                        trt <= trt + 2'd1;
                    end
                end else begin
                    bt <= bt + 2'd1;
                end
            end
        end
    end
endmodule

// File: rtl/bnn_load_tx.sv
// Serialises a 28x28 binary image and 8x3x3 binary weights to the registers block, then awaits load_done.
// First strobe one cycle after start is taken; stall pauses the stream in place, abort returns to idle.
module bnn_load_tx
    import bnn_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              stall,
    input  logic [IMG_DIM-1:0][IMG_DIM-1:0]   pixels_in,
    input  logic [K_DIM-1:0][K_DIM-1:0]       weights_in [0:N_FILT-1],
    input  logic                              load_done,
    output logic                              en_wr,
    output logic                              d_out_p,
    output logic                              d_out_w,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    tx_state_t   state;
    logic [TW-1:0] timer;
    logic [4:0]  row, col;
    logic [2:0]  lvl;
    logic [1:0]  trt, bt;
    logic        w_act, last;
    logic        idle_like, cnt_clr, cnt_en;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign cnt_clr   = !abort && start && idle_like;
    assign cnt_en    = !abort && (state == ST_SEND) && !stall;

    load_seq_counter u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .row     (row),
        .col     (col),
        .lvl     (lvl),
        .trt     (trt),
        .bt      (bt),
        .w_act   (w_act),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            timer   <= '0;
            en_wr   <= 1'b0;
            d_out_p <= 1'b0;
            d_out_w <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            timer   <= '0;
            en_wr   <= 1'b0;
            d_out_p <= 1'b0;
            d_out_w <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state <= ST_SEND;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // data bits keep their last value across a stall
                    if (stall) begin
                        en_wr <= 1'b0;
                    end else begin
                        en_wr   <= 1'b1;
                        d_out_p <= pixels_in[row][col];
                        d_out_w <= w_act ? weights_in[lvl][trt][bt] : 1'b0;
                        if (last) begin
                            state <= ST_WAIT_ACK;
                            timer <= '0;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    en_wr   <= 1'b0;
                    d_out_p <= 1'b0;
                    d_out_w <= 1'b0;
                    if (load_done) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        state <= ST_ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_load_tx.sv
// Randomised bench for bnn_load_tx: stimulus queues expected serial bits, a monitor pops and compares on each strobe.
module tb_bnn_load_tx;
    import bnn_pkg::*;

    localparam int ACK_TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, stall = 1'b0, load_done = 1'b0;
    logic [IMG_DIM-1:0][IMG_DIM-1:0] pix;
    logic [K_DIM-1:0][K_DIM-1:0]     wgt [0:N_FILT-1];
    logic en_wr, d_out_p, d_out_w, busy, done, err;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic [1:0] exp_q [$];
    logic [1:0] exp_e;

    bnn_load_tx #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .pixels_in  (pix),
        .weights_in (wgt),
        .load_done  (load_done),
        .en_wr      (en_wr),
        .d_out_p    (d_out_p),
        .d_out_w    (d_out_w),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // receiver-side scoreboard: every strobe must match the next queued bit pair
    always @(posedge clk) begin
        #1;
        if (en_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_strobe: got strobe with p=%0b w=%0b, expected no strobe", d_out_p, d_out_w);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sb_bits", {30'd0, d_out_p, d_out_w}, {30'd0, exp_e});
            end
            n_strobe++;
            last_cyc = cyc;
        end
    end

    task automatic push_expected();
        logic p, w;
        for (int i = 0; i < N_PIX; i++) begin
            p = pix[i / IMG_DIM][i % IMG_DIM];
            w = (i < N_WGT) ? wgt[i / 9][(i % 9) / 3][i % 3] : 1'b0;
            exp_q.push_back({p, w});
        end
    endtask

    task automatic rand_data();
        for (int r = 0; r < IMG_DIM; r++) pix[r] = 28'($urandom);
        for (int l = 0; l < N_FILT; l++)
            for (int t = 0; t < K_DIM; t++) wgt[l][t] = 3'($urandom);
    endtask

    // ack: 0 = answer with load_done after a short random delay, 1 = never answer
    task automatic run_tx(input int sa_at, input int sa_len, input int sb_at, input int sb_len,
                          input bit rnd, input int start_at, input int abort_at, input int rst_at,
                          input int ack);
        int base, k, left, budget, d;
        bit prev_stall, sa_done, sb_done, st_done;
        push_expected();
        base = n_strobe;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        prev_stall = 1'b0; sa_done = 1'b0; sb_done = 1'b0; st_done = 1'b0;
        left = 0; budget = 0; k = 0;
        while (k < N_PIX && budget < 4000) begin
            @(posedge clk); #2;
            budget++;
            chk("strobe_pattern", en_wr, !prev_stall);
            k = n_strobe - base;
            start = 1'b0;
            if (k == abort_at) begin
                abort = 1'b1;
                stall = 1'b1;
                @(posedge clk); #2;
                abort = 1'b0;
                stall = 1'b0;
                chk("abort_en_wr", en_wr, 0);
                chk("abort_busy", busy, 0);
                chk("abort_count", n_strobe - base, abort_at);
                exp_q.delete();
                return;
            end
            if (k == rst_at) begin
                reset_n = 1'b0;
                stall = 1'b0;
                #1;
                chk("rst_outs", {en_wr, d_out_p, d_out_w, busy, done, err}, 0);
                repeat (2) @(posedge clk);
                #2 reset_n = 1'b1;
                chk("rst_count", n_strobe - base, rst_at);
                exp_q.delete();
                return;
            end
            if (!st_done && k == start_at) begin
                start = 1'b1;
                st_done = 1'b1;
            end
            if (left > 0) begin
                stall = 1'b1;
                left--;
            end else if (!sa_done && k == sa_at) begin
                sa_done = 1'b1; stall = 1'b1; left = sa_len - 1;
            end else if (!sb_done && k == sb_at) begin
                sb_done = 1'b1; stall = 1'b1; left = sb_len - 1;
            end else begin
                stall = rnd && ($urandom_range(0, 3) == 0);
            end
            prev_stall = stall;
        end
        stall = 1'b0;
        start = 1'b0;
        chk("tx_count", k, N_PIX);
        @(posedge clk); #2;
        chk("post_tx_outs", {en_wr, d_out_p, d_out_w}, 0);
        chk("post_tx_busy", busy, 1);
        if (ack == 0) begin
            d = $urandom_range(0, 5);
            repeat (d) begin @(posedge clk); #2; end
            load_done = 1'b1;
            for (int i = 0; i < ACK_TO; i++) begin
                @(posedge clk); #2;
                if (done) break;
            end
            chk("ack_done", done, 1);
            chk("ack_busy", busy, 0);
            chk("ack_err", err, 0);
            load_done = 1'b0;
        end else begin
            for (int i = 0; i < 3 * ACK_TO; i++) begin
                @(posedge clk); #2;
                if (err) break;
            end
            chk("to_latency", cyc - last_cyc, ACK_TO);
            chk("to_err", err, 1);
            chk("to_busy", busy, 0);
            chk("to_done", done, 0);
        end
        chk("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        for (int r = 0; r < IMG_DIM; r++) pix[r] = '0;
        for (int l = 0; l < N_FILT; l++) wgt[l] = '0;

        // reset held five cycles
        repeat (5) @(posedge clk);
        #2;
        chk("reset_en_wr", en_wr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_dp", d_out_p, 0);
        chk("reset_dw", d_out_w, 0);
        reset_n = 1'b1;

        // checkerboard image and weights
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++) pix[r][c] = 1'((r + c) % 2);
        for (int l = 0; l < N_FILT; l++)
            for (int t = 0; t < K_DIM; t++)
                for (int b = 0; b < K_DIM; b++) wgt[l][t][b] = 1'((l + t + b) % 2);
        run_tx(-1, 0, -1, 0, 1'b0, -1, -1, -1, 0);

        // stall and load_done have no effect once finished
        stall = 1'b1; load_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("idle_done_held", done, 1);
        chk("idle_no_strobe", en_wr, 0);
        chk("idle_busy", busy, 0);
        stall = 1'b0; load_done = 1'b0;

        rand_data();
        run_tx(50, 10, 700, 3, 1'b0, -1, -1, -1, 0);

        rand_data();
        run_tx(-1, 0, -1, 0, 1'b1, -1, -1, -1, 1);

        rand_data();
        run_tx(-1, 0, -1, 0, 1'b0, -1, 400, -1, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("post_abort_idle", {en_wr, busy, done, err}, 0);
        for (int r = 0; r < IMG_DIM; r++) pix[r] = '1;
        for (int l = 0; l < N_FILT; l++) wgt[l] = '0;
        run_tx(-1, 0, -1, 0, 1'b0, -1, -1, -1, 0);

        rand_data();
        run_tx(-1, 0, -1, 0, 1'b1, 60, -1, 100, 0);
        #2;
        chk("post_rst_idle", {en_wr, d_out_p, d_out_w, busy, done, err}, 0);
        rand_data();
        run_tx(-1, 0, -1, 0, 1'b1, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end
endmodule
